muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with an integrated HI/LO register pair, serving MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Generalises the fixed 32-bit divider with busy/over handshake: WIDTH-generic, one shared datapath for all four ops, explicit FSM, and a PC-stall output.
- Sits beside the cpu datapath. Operands come from the register file; hi/lo feed the writeback mux.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_iter_step.sv | 31 +++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - operation encoding, FSM states and op helpers for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } md_state_t;

    function automatic logic is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the cpu datapath and the multiply/divide unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;
    logic             div_zero;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, stall, div_zero
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done, stall, div_zero
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// rtl/muldiv_iter_step.sv - one combinational shift-add or restoring-divide iteration
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] opnd,
    input  logic               in_bit,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    localparam int W = WIDTH;

    logic [W:0]   shifted;
    logic [W+1:0] diff;

    // Divide: acc[W:0] is the partial remainder, in_bit the next dividend bit.
    // Multiply: opnd is the already-shifted multiplicand, in_bit the current multiplier bit.
    always_comb begin
        shifted  = {acc[W-1:0], in_bit};
        diff     = {1'b0, shifted} - {2'b00, opnd[W-1:0]};
        acc_next = acc;
        q_bit    = 1'b0;
        if (div_mode) begin
            q_bit    = ~diff[W+1];
            acc_next = {{(W-1){1'b0}}, (q_bit ? diff[W:0] : shifted)};
        end else if (in_bit) begin
            acc_next = acc + opnd;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO; MULDIV_EARLY_EXIT_EN enables multiply early exit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic     clk_in,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int W = WIDTH;

    md_state_t          state;
    md_op_t             op_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     opnd;
    logic [W-1:0]       shreg;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res;
    logic               neg_rem;
    logic [W-1:0]       hi_r;
    logic [W-1:0]       lo_r;
    logic               done_r;
    logic               dz_r;

    logic               sgn;
    logic               div_op;
    logic [W-1:0]       a_mag;
    logic [W-1:0]       b_mag;
    logic [2*W-1:0]     acc_next;
    logic               q_bit;
    logic               step_bit;
    logic               early_exit;
    logic [2*W-1:0]     prod;
    logic [W-1:0]       quo;
    logic [W-1:0]       rem;
    logic [W-1:0]       fix_hi;
    logic [W-1:0]       fix_lo;

    assign sgn      = is_signed(op_r);
    assign div_op   = is_div(op_r);
    assign step_bit = div_op ? shreg[W-1] : shreg[0];

    muldiv_iter_step #(.WIDTH(W)) u_step (
        .div_mode (div_op),
        .acc      (acc),
        .opnd     (opnd),
        .in_bit   (step_bit),
        .acc_next (acc_next),
        .q_bit    (q_bit)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    // Once the multiplier bits still to be consumed are all zero, further adds would be no-ops.
    assign early_exit = !div_op && (shreg[W-1:1] == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        a_mag = (sgn && a_r[W-1]) ? (~a_r + 1'b1) : a_r;
        b_mag = (sgn && b_r[W-1]) ? (~b_r + 1'b1) : b_r;
    end

    // Sign fix-up; MIN / -1 falls out naturally since -MIN wraps back to MIN.
    always_comb begin
        prod   = neg_res ? (~acc + 1'b1) : acc;
        quo    = neg_res ? (~shreg + 1'b1) : shreg;
        rem    = neg_rem ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        fix_hi = prod[2*W-1:W];
        fix_lo = prod[W-1:0];
        if (div_op) begin
            if (dz_r) begin
                fix_hi = a_r;
                fix_lo = '1;
            end else begin
                fix_hi = rem;
                fix_lo = quo;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_r    <= MD_MULT;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            opnd    <= '0;
            shreg   <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start) begin
                        op_r  <= md_op_t'(bus.op);
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        dz_r  <= 1'b0;
                        state <= PREP;
                    end
                end
                PREP: begin
                    acc     <= '0;
                    cnt     <= '0;
                    neg_res <= sgn && (a_r[W-1] ^ b_r[W-1]);
                    if (div_op) begin
                        opnd    <= {{W{1'b0}}, b_mag};
                        shreg   <= a_mag;
                        neg_rem <= sgn && a_r[W-1];
                        if (b_r == '0) dz_r <= 1'b1;
                    end else begin
                        opnd    <= {{W{1'b0}}, a_mag};
                        shreg   <= b_mag;
                        neg_rem <= 1'b0;
                    end
                    state <= CALC;
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (div_op) begin
                        shreg <= {shreg[W-2:0], q_bit};
                    end else begin
                        opnd  <= opnd << 1;
                        shreg <= shreg >> 1;
                    end
                    if (cnt == CNT_W'(W-1) || early_exit) state <= FIX;
                end
                FIX: begin
                    hi_r   <= fix_hi;
                    lo_r   <= fix_lo;
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.busy     = (state != IDLE);
    assign bus.stall    = (bus.start && state == IDLE) ||
                          (state == PREP) || (state == CALC) || (state == FIX);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized scoreboard bench for muldiv_unit at WIDTH=32 plus directed WIDTH=8 cases
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscmp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut (.clk_in(clk), .reset(rst_n), .bus(bus));
    muldiv_unit #(.WIDTH(8))  dut8 (.clk_in(clk), .reset(rst_n), .bus(bus8));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected cycles from accepting edge to the edge that raises done.
    function automatic int exp_lat(input int w, input bit mul, input logic [63:0] bmag);
        int k;
        k = 0;
`ifdef MULDIV_EARLY_EXIT_EN
        if (mul) begin
            for (int i = 0; i < w; i++) if (bmag[i]) k = i + 1;
            if (k < 1) k = 1;
            return k + 2;
        end
`endif
        return w + 2 + k * 0 + (mul && bmag[0] && 1'b0 ? 1 : 0);
    endfunction

    function automatic void ref32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output bit dz,
                                  output int lat);
        logic [63:0] p;
        logic [31:0] bmag;
        int sa, sb;
        dz = 1'b0;
        sa = a;
        sb = b;
        bmag = b;
        case (op)
            MD_MULT: begin
                p = longint'(sa) * longint'(sb);
                hi = p[63:32];
                lo = p[31:0];
                if (sb < 0) bmag = -b;
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    dz = 1'b1;
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'h0;
                end else if (op == MD_DIV) begin
                    lo = sa / sb;
                    hi = sa % sb;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
        lat = exp_lat(32, !op[1], {32'd0, bmag});
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscmp++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
                chk({mon_e.name, "_dz"}, bus.div_zero, mon_e.dz);
                chk({mon_e.name, "_lat"}, cyc - mon_e.t0, mon_e.lat);
                chk({mon_e.name, "_stall_in_done"}, bus.stall, 0);
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input string nm, input bit disturb, input bit with_we);
        exp_t e;
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = av;
        bus.b = bv;
        if (with_we) begin
            bus.hi_we = 1'b1;
            bus.wdata = 32'h1357_9BDF;
        end
        ref32(op, av, bv, e.hi, e.lo, e.dz, e.lat);
        e.name = nm;
        @(posedge clk);
        #1;
        e.t0 = cyc;
        sbq.push_back(e);
        chk({nm, "_dz_cleared"}, bus.div_zero, 0);
        chk({nm, "_busy"}, bus.busy, 1);
        if (with_we) chk({nm, "_hi_we_with_start"}, bus.hi, 32'h1357_9BDF);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        if (disturb) begin
            repeat (4) @(negedge clk);
            bus.start = 1'b1;
            bus.hi_we = 1'b1;
            bus.lo_we = 1'b1;
            bus.wdata = 32'hAAAA_0000;
            @(negedge clk);
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            chk({nm, "_busy_after_ignored"}, bus.busy, 1);
        end
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            vectors++;
            miscmp++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", nm);
        end
        @(negedge clk);
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ehi, input logic [7:0] elo, input int elat, input string nm);
        int t0, n;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op = op;
        bus8.a = av;
        bus8.b = bv;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        bus8.start = 1'b0;
        n = 0;
        while (!bus8.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, bus8.done, 1);
        chk({nm, "_hi"}, bus8.hi, ehi);
        chk({nm, "_lo"}, bus8.lo, elo);
        chk({nm, "_lat"}, cyc - t0, elat);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          sel;
        int          n;

        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0;
        bus8.hi_we = 0; bus8.lo_we = 0; bus8.wdata = 0;

        repeat (3) @(negedge clk);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dz", bus.div_zero, 0);
        chk("rst_stall", bus.stall, 0);
        #2 rst_n = 1'b1;

        @(negedge clk);
        bus.start = 1'b1;
        #1 chk("stall_on_start_idle", bus.stall, 1);
        bus.start = 1'b0;

        do_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_m3x5",     0, 0);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max",     0, 0);
        do_op(MD_DIVU,  32'd100,       32'd7,         "divu_100_7",    0, 0);
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         "div_m7_2",      0, 0);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1",    0, 0);
        do_op(MD_DIV,   32'h1234_5678, 32'd0,         "div_by_zero",   0, 0);
        do_op(MD_MULT,  32'd6,         32'hFFFF_FFF9, "mult_clear_dz", 1, 0);
        do_op(MD_MULTU, 32'd3,         32'd4,         "multu_with_we", 0, 1);
        do_op(MD_DIVU,  32'hDEAD_BEEF, 32'd0,         "divu_by_zero",  1, 0);
`ifdef MULDIV_EARLY_EXIT_EN
        do_op(MD_MULTU, 32'h1234,      32'd1,         "multu_early_1", 0, 0);
        do_op(MD_MULT,  32'h1234,      32'd0,         "mult_early_0",  0, 0);
`endif

        for (int i = 0; i < 36; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = $urandom_range(1, 15);
            if (sel == 3) ra = $urandom_range(0, 255);
            if (sel == 4) rb = -($urandom_range(1, 300));
            do_op(rop, ra, rb, "rand", (sel == 5), 0);
        end

        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_0055;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_0066;
        chk("mthi", bus.hi, 32'h55);
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo", bus.lo, 32'h66);
        chk("mtlo_hi_kept", bus.hi, 32'h55);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op = MD_MULTU;
        bus.a = 32'hFFFF_0000;
        bus.b = 32'h0001_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_calc_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        chk("abort_stall", bus.stall, 0);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_result_hi", bus.hi, 0);
        chk("abort_no_result_lo", bus.lo, 0);

        run8(MD_MULT,  8'h7F, 8'h7F, 8'h3F, 8'h01, exp_lat(8, 1, 64'h7F), "w8_mult_7f");
        run8(MD_DIV,   8'h80, 8'hFF, 8'h00, 8'h80, exp_lat(8, 0, 64'h0),  "w8_div_min_m1");
        run8(MD_DIVU,  8'hC3, 8'h00, 8'hC3, 8'hFF, exp_lat(8, 0, 64'h0),  "w8_divu_zero");
        chk("w8_dz", bus8.div_zero, 1);
        run8(MD_MULT,  8'h80, 8'hFF, 8'h00, 8'h80, exp_lat(8, 1, 64'h1),  "w8_mult_min_m1");
        run8(MD_DIVU,  8'hFA, 8'h07, 8'h05, 8'h23, exp_lat(8, 0, 64'h0),  "w8_divu_250_7");

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end
endmodule
